// File: rtl/meteor_scheduler.sv
// rtl/meteor_scheduler.sv - meteor spawn/move/retire scheduler with lives and hit handling
module meteor_scheduler #(
  parameter int SPAWN_PERIOD  = 60,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int Y_LIMIT       = 480
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        ball_die,
  output logic [9:0]  enemy_x     [4],
  output logic [9:0]  enemy_y     [4],
  output logic [9:0]  enemy_size  [4],
  output logic        enemy_alive [4],
  output logic [1:0]  game_state,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic        ball_reset
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_t;

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [9:0]  x_q     [4];
  logic [9:0]  y_q     [4];
  logic [9:0]  size_q  [4];
  logic [1:0]  speed_q [4];   // holds speed-1 so the 1..4 range fits in two bits
  logic [3:0]  alive_q;
  logic [1:0]  lives_q;
  logic [15:0] score_q;
  logic        ball_reset_q;
  logic [15:0] spawn_cnt_q;
  logic [15:0] invuln_q;

  logic [15:0] lfsr_d;
  logic [9:0]  spawn_x;
  logic        spawn_now;
  logic        hit_now;
  logic [3:0]  spawn_onehot;
  logic [10:0] y_next [4];
  logic [3:0]  retire;
  logic [2:0]  n_retire;
  logic [16:0] score_sum;

  always_comb begin
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    spawn_x      = (lfsr_q[9:0] >= 10'd600) ? (lfsr_q[9:0] - 10'd512) : lfsr_q[9:0];
    spawn_now    = (spawn_cnt_q == 16'(SPAWN_PERIOD - 1));
    hit_now      = ball_die && (invuln_q == 16'd0);
    spawn_onehot = 4'b0000;
    n_retire     = 3'd0;
    // Scan downward so the lowest free index wins.
    for (int i = 3; i >= 0; i--) begin
      if (!alive_q[i]) spawn_onehot = 4'b0001 << i;
    end
    for (int i = 0; i < 4; i++) begin
      y_next[i] = {1'b0, y_q[i]} + {9'b0, speed_q[i]} + 11'd1;
      retire[i] = alive_q[i] && (y_next[i] >= 11'(Y_LIMIT));
      n_retire  = n_retire + {2'b0, retire[i]};
    end
    score_sum = {1'b0, score_q} + {14'b0, n_retire};
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      lfsr_q       <= 16'hACE1;
      alive_q      <= 4'b0000;
      lives_q      <= 2'd0;
      score_q      <= 16'd0;
      ball_reset_q <= 1'b0;
      spawn_cnt_q  <= 16'd0;
      invuln_q     <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        x_q[i]     <= 10'd0;
        y_q[i]     <= 10'd0;
        size_q[i]  <= 10'd0;
        speed_q[i] <= 2'd0;
      end
    end else begin
      lfsr_q       <= lfsr_d;
      ball_reset_q <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            state_q      <= PLAY;
            lives_q      <= 2'(LIVES_INIT);
            score_q      <= 16'd0;
            spawn_cnt_q  <= 16'd0;
            invuln_q     <= 16'd0;
            alive_q      <= 4'b0000;
            ball_reset_q <= 1'b1;
          end
        end
        PLAY: begin
          if (hit_now) begin
            lives_q <= lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_q <= OVER;
            end else begin
              state_q      <= HIT;
              alive_q      <= 4'b0000;
              ball_reset_q <= 1'b1;
              invuln_q     <= 16'(INVULN_FRAMES);
              spawn_cnt_q  <= 16'd0;
            end
          end else begin
            if (invuln_q != 16'd0) invuln_q <= invuln_q - 16'd1;
            spawn_cnt_q <= spawn_now ? 16'd0 : spawn_cnt_q + 16'd1;
            score_q     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            for (int i = 0; i < 4; i++) begin
              if (alive_q[i]) begin
                if (retire[i]) alive_q[i] <= 1'b0;
                else           y_q[i]     <= y_next[i][9:0];
              end else if (spawn_now && spawn_onehot[i]) begin
                alive_q[i] <= 1'b1;
                y_q[i]     <= 10'd0;
                x_q[i]     <= spawn_x;
                size_q[i]  <= 10'd16 + {5'b0, lfsr_q[11:10], 3'b000};
                speed_q[i] <= lfsr_q[13:12];
              end
            end
          end
        end
        HIT: state_q <= PLAY;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      enemy_x[i]     = x_q[i];
      enemy_y[i]     = y_q[i];
      enemy_size[i]  = size_q[i];
      enemy_alive[i] = alive_q[i];
    end
  end

  assign game_state = state_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign ball_reset = ball_reset_q;

endmodule

// File: tb/tb_meteor_scheduler.sv
// tb/tb_meteor_scheduler.sv - randomized scoreboard bench for meteor_scheduler
module tb_meteor_scheduler;

  localparam int SP = 60;
  localparam int LI = 3;
  localparam int IF = 120;
  localparam int YL = 480;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       ball_die = 1'b0;
  logic [9:0] enemy_x [4];
  logic [9:0] enemy_y [4];
  logic [9:0] enemy_size [4];
  logic       enemy_alive [4];
  logic [1:0] game_state;
  logic [1:0] lives;
  logic [15:0] score;
  logic       ball_reset;

  meteor_scheduler #(.SPAWN_PERIOD(SP), .LIVES_INIT(LI), .INVULN_FRAMES(IF), .Y_LIMIT(YL)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start), .ball_die(ball_die),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_size(enemy_size), .enemy_alive(enemy_alive),
    .game_state(game_state), .lives(lives), .score(score), .ball_reset(ball_reset)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [1:0]       st;
    logic [1:0]       lives;
    logic [15:0]      score;
    logic             br;
    logic [3:0]       alive;
    logic [3:0][9:0]  x;
    logic [3:0][9:0]  y;
    logic [3:0][9:0]  sz;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // Reference model: game rules in plain integer arithmetic
  int m_st, m_lives, m_score, m_br, m_inv, m_cnt, m_lfsr;
  int m_alive[4], m_x[4], m_y[4], m_sz[4], m_sp[4];

  function automatic void model_reset();
    m_st = 0; m_lives = 0; m_score = 0; m_br = 0; m_inv = 0; m_cnt = 0; m_lfsr = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      m_alive[i] = 0; m_x[i] = 0; m_y[i] = 0; m_sz[i] = 0; m_sp[i] = 0;
    end
  endfunction

  function automatic void model_step(input int st_in, input int die);
    int fb, free_slot, spawn, raw_x;
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_br = 0;
    if (m_st == 0 || m_st == 3) begin
      if (st_in != 0) begin
        m_st = 1; m_lives = LI; m_score = 0; m_cnt = 0; m_inv = 0; m_br = 1;
        for (int i = 0; i < 4; i++) m_alive[i] = 0;
      end
    end else if (m_st == 2) begin
      m_st = 1;
    end else if (die != 0 && m_inv == 0) begin
      m_lives = m_lives - 1;
      if (m_lives == 0) m_st = 3;
      else begin
        m_st = 2; m_br = 1; m_inv = IF; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_alive[i] = 0;
      end
    end else begin
      if (m_inv > 0) m_inv = m_inv - 1;
      spawn = (m_cnt == SP - 1);
      m_cnt = spawn ? 0 : m_cnt + 1;
      free_slot = -1;
      for (int i = 0; i < 4; i++) if (m_alive[i] == 0 && free_slot < 0) free_slot = i;
      for (int i = 0; i < 4; i++) begin
        if (m_alive[i] != 0) begin
          if (m_y[i] + m_sp[i] >= YL) begin
            m_alive[i] = 0;
            if (m_score < 65535) m_score = m_score + 1;
          end else m_y[i] = m_y[i] + m_sp[i];
        end
      end
      if (spawn && free_slot >= 0) begin
        raw_x = m_lfsr % 1024;
        m_alive[free_slot] = 1;
        m_y[free_slot] = 0;
        m_x[free_slot] = (raw_x >= 600) ? raw_x - 512 : raw_x;
        m_sz[free_slot] = 16 + 8 * ((m_lfsr / 1024) % 4);
        m_sp[free_slot] = 1 + (m_lfsr / 4096) % 4;
      end
    end
    m_lfsr = ((m_lfsr * 2) + fb) % 65536;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.st = 2'(m_st); s.lives = 2'(m_lives); s.score = 16'(m_score); s.br = m_br[0];
    for (int i = 0; i < 4; i++) begin
      s.alive[i] = m_alive[i][0]; s.x[i] = 10'(m_x[i]); s.y[i] = 10'(m_y[i]); s.sz[i] = 10'(m_sz[i]);
    end
    return s;
  endfunction

  function automatic int model_alive_count();
    int n = 0;
    for (int i = 0; i < 4; i++) n += m_alive[i];
    return n;
  endfunction

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  initial begin
    snap_t e;
    wait (mon_en);
    forever begin
      @(posedge frame_clk or posedge Reset);
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_underflow at %0t: got 0 entries expected >=1", $time);
      end else begin
        e = exp_q.pop_front();
        cmp("game_state", int'(game_state), int'(e.st));
        cmp("lives", int'(lives), int'(e.lives));
        cmp("score", int'(score), int'(e.score));
        cmp("ball_reset", int'(ball_reset), int'(e.br));
        for (int i = 0; i < 4; i++) begin
          cmp($sformatf("alive%0d", i), int'(enemy_alive[i]), int'(e.alive[i]));
          if (e.alive[i] || Reset) begin
            cmp($sformatf("x%0d", i), int'(enemy_x[i]), int'(e.x[i]));
            cmp($sformatf("y%0d", i), int'(enemy_y[i]), int'(e.y[i]));
            cmp($sformatf("size%0d", i), int'(enemy_size[i]), int'(e.sz[i]));
          end
        end
      end
    end
  end

  task automatic frame(input bit s, input bit d);
    @(negedge frame_clk);
    start = s;
    ball_die = d;
    model_step(int'(s), int'(d));
    exp_q.push_back(model_snap());
  endtask

  // Async reset pulse away from the clock edge; one entry for the reset edge, one for the clock edge under reset.
  task automatic pulse_reset();
    @(negedge frame_clk);
    #2;
    model_reset();
    exp_q.push_back(model_snap());
    exp_q.push_back(model_snap());
    Reset = 1'b1;
    @(posedge frame_clk);
    #3;
    Reset = 1'b0;
  endtask

  initial begin
    int resets_done;
    model_reset();
    repeat (3) @(posedge frame_clk);
    #3;
    Reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) frame(1'b0, 1'($urandom_range(0, 1)));
    frame(1'b1, 1'b0);
    for (int i = 0; i < 800; i++) frame(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 260; i++) frame(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) frame(1'b0, 1'($urandom_range(0, 1)));
    frame(1'b1, 1'b0);

    resets_done = 0;
    for (int i = 0; i < 2200; i++) begin
      if (m_st == 1 && model_alive_count() >= 3 && resets_done < 4 && $urandom_range(0, 19) == 0) begin
        pulse_reset();
        resets_done++;
      end else begin
        frame(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 59) == 0));
      end
    end
    pulse_reset();
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);

    @(posedge frame_clk);
    #3;
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/meteor_scheduler.md
METEOR_SCHEDULER -- requirements
Module: meteor_scheduler

Interface
REQ-001 SHALL provide parameter SPAWN_PERIOD, default 60, frames between spawn attempts.
REQ-002 SHALL provide parameter LIVES_INIT, default 3, lives loaded at game start (range 1..3).
REQ-003 SHALL provide parameter INVULN_FRAMES, default 120, frames of hit immunity after respawn.
REQ-004 SHALL provide parameter Y_LIMIT, default 480, meteor y at or beyond which a slot retires.
REQ-005 SHALL have port frame_clk  input  1  frame-rate clock, all logic on rising edge.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  level, decoded start key.
REQ-008 SHALL have port ball_die  input  1  player/meteor collision flag from player block.
REQ-009 SHALL have ports enemy_x[4], enemy_y[4], enemy_size[4]  output  10 each  per-slot meteor geometry.
REQ-010 SHALL have port enemy_alive[4]  output  1 each  slot occupied.
REQ-011 SHALL have port game_state  output  2  0 IDLE, 1 PLAY, 2 HIT, 3 OVER.
REQ-012 SHALL have port lives  output  2  remaining lives.
REQ-013 SHALL have port score  output  16  retired-meteor count.
REQ-014 SHALL have port ball_reset  output  1  one-frame pulse re-centring the player.

Function
REQ-015 SHALL implement FSM IDLE, PLAY, HIT, OVER; all outputs registered, one frame latency from input to effect.
REQ-016 IDLE/OVER: start=1 SHALL enter PLAY next frame with lives=LIVES_INIT, score=0, spawn counter=0, invuln=0, all slots freed.
REQ-017 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1, advancing every frame in every state, never reaching zero.
REQ-018 PLAY: spawn counter increments each frame; at SPAWN_PERIOD-1 it clears and a spawn attempt occurs.
REQ-019 Spawn SHALL allocate the lowest-index slot whose enemy_alive was 0 at the start of the frame; no free slot -> attempt dropped, counter still clears.
REQ-020 Spawned slot: y=0; size=16+8*lfsr[11:10]; speed=1+lfsr[13:12] (per-slot 2-bit register); x=lfsr[9:0], minus 512 when >=600.
REQ-021 PLAY: each alive slot y <= y+speed per frame (11-bit compare, no 10-bit wrap); if y+speed >= Y_LIMIT the slot frees and score increments, saturating at 16'hFFFF; multiple retirements in one frame each add 1.
REQ-022 A slot freed in frame N SHALL NOT be re-allocated before frame N+1.
REQ-023 PLAY, ball_die=1 and invuln=0: lives decrement; lives was 1 -> OVER, else HIT; spawn and movement suppressed that frame.
REQ-024 ball_die SHALL be ignored while invuln>0; invuln decrements by 1 per PLAY frame, floor 0.
REQ-025 HIT: lasts exactly one frame, frees all slots, asserts ball_reset, loads invuln=INVULN_FRAMES, clears spawn counter, returns to PLAY.
REQ-026 ball_reset SHALL be 1 only during the HIT frame and the first PLAY frame after IDLE/OVER.
REQ-027 OVER: slots frozen (no movement, no spawn, no retirement), score and lives held.
REQ-028 start while in PLAY or HIT SHALL have no effect.

Reset
REQ-029 Reset=1 SHALL asynchronously force IDLE, all slots freed with x=y=size=0, lives=0, score=0, ball_reset=0, counters 0, LFSR=16'hACE1, including mid-spawn or mid-HIT.
REQ-030 After Reset deasserts, first state change SHALL occur only on a frame_clk edge with start=1.

Verification
REQ-031 Reset, start=1 one frame -> game_state=1, lives=3, score=0, ball_reset=1 that frame, all enemy_alive=0.
REQ-032 PLAY 60 frames, ball_die=0 -> slot 0 alive with y=0, size in {16,24,32,40}, x<600; second spawn at frame 120 into slot 1.
REQ-033 Four slots alive, spawn attempt -> no slot changes, counter clears; slot with y=478 speed 2 -> freed, score=1.
REQ-034 ball_die=1 in PLAY with lives=3 -> HIT one frame, lives=2, all slots freed, ball_reset=1; ball_die held 120 frames -> no further decrement; frame 121 -> lives=1.
REQ-035 lives=1, ball_die=1 -> OVER, slots frozen, score held; start=1 -> PLAY, lives=3, score=0.
REQ-036 Reset pulsed mid-PLAY with 3 slots alive -> immediately IDLE, all outputs at reset values.
